cmd_cfg_gen: RTL and testbench

Parametrised successor to the quadcopter command-configuration block. It sits between UART_comm (cmd_rdy/cmd/data in, resp/send_resp out) and the flight controller, inertial integrator and ESCs. It decodes opcodes into NUM_SP setpoint registers plus thrust, and sequences calibration with a motor spin-up delay and a calibration timeout. It also drives emergency land, motors-off and NAK responses.

---
 rtl/cmd_cfg_gen_if.sv | 37 +++
 rtl/cmd_cfg_gen.sv | 266 ++++++++++++++++++++++++++
 tb/tb_cmd_cfg_gen.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_cfg_gen_if.sv
// ---------------------------------------------------------------------------
// cmd_cfg_gen_if
// Command/response link between UART_comm and cmd_cfg_gen.
//   cmd_rdy     : command pending (UART_comm -> cmd_cfg_gen)
//   cmd         : 8-bit opcode
//   data        : 16-bit payload
//   clr_cmd_rdy : consume pulse back to UART_comm
//   resp        : response byte
//   send_resp   : one-cycle response strobe
// Modports: master = UART_comm side, slave = cmd_cfg_gen side.
// ---------------------------------------------------------------------------
interface cmd_cfg_gen_if;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;

  modport master (
    output cmd_rdy,
    output cmd,
    output data,
    input  clr_cmd_rdy,
    input  resp,
    input  send_resp
  );

  modport slave (
    input  cmd_rdy,
    input  cmd,
    input  data,
    output clr_cmd_rdy,
    output resp,
    output send_resp
  );
endinterface

// File: rtl/cmd_cfg_gen.sv
// ---------------------------------------------------------------------------
// cmd_cfg_gen
// Decodes UART commands into NUM_SP setpoint registers plus thrust, and
// sequences gyro calibration: motor spin-up delay (MTR_RAMP cycles), a
// one-cycle strt_cal pulse, then wait for cal_done with a CAL_TMO timeout.
// Also handles emergency land, motors-off and NAK of unknown opcodes.
//
// Optional feature (macro CMD_CFG_WDOG_EN): command-silence watchdog. While
// motors run and the block is idle, WDOG_CYC cycles without a consumed
// command zero all setpoints/thrust and set the sticky wdog_trip flag, which
// only MTSOFF or reset clears. Without the macro wdog_trip is tied low.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : cmd_rdy/cmd/data in, clr_cmd_rdy/resp/send_resp out
//   sp_out       : packed setpoints, channel i at [i*SP_W +: SP_W]
//   thrst        : thrust
//   strt_cal     : one-cycle calibration start
//   inertial_cal : high while calibration is in progress
//   cal_done     : calibration complete (only honoured in CAL state)
//   motors_off   : ESC shutdown
//   wdog_trip    : sticky comm-loss flag
// ---------------------------------------------------------------------------
module cmd_cfg_gen #(
  parameter int          NUM_SP   = 3,
  parameter int          SP_W     = 16,
  parameter int          THR_W    = 9,
  parameter logic [7:0]  SP_BASE  = 8'h02,
  parameter logic [24:0] MTR_RAMP = 25'h1FF_FFFF,
  parameter logic [23:0] CAL_TMO  = 24'hFF_FFFF,
  parameter logic [25:0] WDOG_CYC = 26'h3FF_FFFF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cmd_cfg_gen_if.slave           bus,
  output logic [NUM_SP*SP_W-1:0] sp_out,
  output logic [THR_W-1:0]       thrst,
  output logic                   strt_cal,
  output logic                   inertial_cal,
  input  logic                   cal_done,
  output logic                   motors_off,
  output logic                   wdog_trip
);

  localparam logic [7:0] OP_STTHRST = SP_BASE + 8'(NUM_SP);
  localparam logic [7:0] OP_CAL     = OP_STTHRST + 8'd1;
  localparam logic [7:0] OP_EMER    = OP_STTHRST + 8'd2;
  localparam logic [7:0] OP_MTSOFF  = OP_STTHRST + 8'd3;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_NAK = 8'hEE;
  localparam logic [7:0] RESP_CTO = 8'hCE;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RAMP = 2'd1;
  localparam logic [1:0] ST_CAL  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [24:0]            ramp_cnt_q, ramp_cnt_d;
  logic [23:0]            tmo_cnt_q, tmo_cnt_d;
  logic [NUM_SP*SP_W-1:0] sp_q, sp_d;
  logic [THR_W-1:0]       thrst_q, thrst_d;
  logic                   motors_off_q, motors_off_d;
  logic                   inertial_cal_q, inertial_cal_d;
  logic                   strt_cal_q, strt_cal_d;

  logic [NUM_SP-1:0]      sp_sel_s;
  logic                   sp_hit_s;
  logic                   ramp_done_s;
  logic                   clr_cmd_rdy_s;
  logic                   send_resp_s;
  logic [7:0]             resp_s;

`ifdef CMD_CFG_WDOG_EN
  logic [25:0]            silence_cnt_q, silence_cnt_d;
  logic                   wdog_trip_q, wdog_trip_d;
`else
  // Watchdog compiled out: flag is a constant low.
  localparam logic WDOG_TIE_LP = 1'b0 & (|WDOG_CYC);
`endif

  // Ramp ends once MTR_RAMP cycles have been spent in RAMP (also covers 0).
  assign ramp_done_s = ({1'b0, ramp_cnt_q} + 26'd1) >= {1'b0, MTR_RAMP};

  // One-hot decode of the setpoint opcode window SP_BASE .. SP_BASE+NUM_SP-1.
  always_comb begin
    sp_sel_s = '0;
    for (int i = 0; i < NUM_SP; i++) begin
      if (bus.cmd == (SP_BASE + 8'(i))) begin
        sp_sel_s[i] = 1'b1;
      end else begin
        sp_sel_s[i] = 1'b0;
      end
    end
  end

  assign sp_hit_s = |sp_sel_s;

  // Command decode, calibration sequencing and next-state computation.
  always_comb begin
    state_d        = state_q;
    ramp_cnt_d     = ramp_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;
    sp_d           = sp_q;
    thrst_d        = thrst_q;
    motors_off_d   = motors_off_q;
    inertial_cal_d = inertial_cal_q;
    strt_cal_d     = 1'b0;
    clr_cmd_rdy_s  = 1'b0;
    send_resp_s    = 1'b0;
    resp_s         = 8'h00;
`ifdef CMD_CFG_WDOG_EN
    silence_cnt_d  = silence_cnt_q;
    wdog_trip_d    = wdog_trip_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_rdy) begin
          clr_cmd_rdy_s = 1'b1;
          send_resp_s   = 1'b1;
          resp_s        = RESP_ACK;
`ifdef CMD_CFG_WDOG_EN
          silence_cnt_d = 26'd0;
`endif
          if (sp_hit_s) begin
            for (int i = 0; i < NUM_SP; i++) begin
              if (sp_sel_s[i]) begin
                sp_d[i*SP_W +: SP_W] = bus.data[SP_W-1:0];
              end else begin
                sp_d[i*SP_W +: SP_W] = sp_q[i*SP_W +: SP_W];
              end
            end
          end else begin
            case (bus.cmd)
              OP_STTHRST: begin
                thrst_d = bus.data[THR_W-1:0];
              end
              OP_CAL: begin
                // Calibration answers later, when it finishes or times out.
                send_resp_s    = 1'b0;
                resp_s         = 8'h00;
                motors_off_d   = 1'b0;
                inertial_cal_d = 1'b1;
                ramp_cnt_d     = 25'd0;
                state_d        = ST_RAMP;
              end
              OP_EMER: begin
                sp_d    = '0;
                thrst_d = '0;
              end
              OP_MTSOFF: begin
                motors_off_d = 1'b1;
`ifdef CMD_CFG_WDOG_EN
                wdog_trip_d  = 1'b0;
`endif
              end
              default: begin
                resp_s = RESP_NAK;
              end
            endcase
          end
        end else begin
`ifdef CMD_CFG_WDOG_EN
          // Silence only counts while motors spin; saturates at WDOG_CYC.
          if (!motors_off_q) begin
            if (silence_cnt_q >= WDOG_CYC) begin
              sp_d        = '0;
              thrst_d     = '0;
              wdog_trip_d = 1'b1;
            end else begin
              silence_cnt_d = silence_cnt_q + 26'd1;
            end
          end else begin
            silence_cnt_d = silence_cnt_q;
          end
`else
          clr_cmd_rdy_s = 1'b0;
`endif
        end
      end

      ST_RAMP: begin
        if (ramp_done_s) begin
          strt_cal_d = 1'b1;
          tmo_cnt_d  = 24'd0;
          state_d    = ST_CAL;
        end else begin
          ramp_cnt_d = ramp_cnt_q + 25'd1;
        end
      end

      ST_CAL: begin
        // cal_done takes priority over a simultaneous timeout.
        if (cal_done) begin
          send_resp_s    = 1'b1;
          resp_s         = RESP_ACK;
          inertial_cal_d = 1'b0;
          state_d        = ST_IDLE;
        end else if (tmo_cnt_q >= CAL_TMO) begin
          send_resp_s    = 1'b1;
          resp_s         = RESP_CTO;
          inertial_cal_d = 1'b0;
          motors_off_d   = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 24'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      ramp_cnt_q     <= 25'd0;
      tmo_cnt_q      <= 24'd0;
      sp_q           <= '0;
      thrst_q        <= '0;
      motors_off_q   <= 1'b1;
      inertial_cal_q <= 1'b0;
      strt_cal_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      ramp_cnt_q     <= ramp_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      sp_q           <= sp_d;
      thrst_q        <= thrst_d;
      motors_off_q   <= motors_off_d;
      inertial_cal_q <= inertial_cal_d;
      strt_cal_q     <= strt_cal_d;
    end
  end

`ifdef CMD_CFG_WDOG_EN
  // Watchdog silence counter and sticky trip flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      silence_cnt_q <= 26'd0;
      wdog_trip_q   <= 1'b0;
    end else begin
      silence_cnt_q <= silence_cnt_d;
      wdog_trip_q   <= wdog_trip_d;
    end
  end

  assign wdog_trip = wdog_trip_q;
`else
  assign wdog_trip = WDOG_TIE_LP;
`endif

  assign bus.clr_cmd_rdy = clr_cmd_rdy_s;
  assign bus.send_resp   = send_resp_s;
  assign bus.resp        = resp_s;
  assign sp_out          = sp_q;
  assign thrst           = thrst_q;
  assign motors_off      = motors_off_q;
  assign inertial_cal    = inertial_cal_q;
  assign strt_cal        = strt_cal_q;

endmodule

// File: tb/tb_cmd_cfg_gen.sv
// Self-checking bench for cmd_cfg_gen (NUM_SP=3, MTR_RAMP=16, CAL_TMO=32).
module tb_cmd_cfg_gen;
  localparam int NUM_SP     = 3;
  localparam int SP_W       = 16;
  localparam int THR_W      = 9;
  localparam int MTR_RAMP_I = 16;
  localparam int CAL_TMO_I  = 32;
  localparam int WDOG_I     = 100;
  localparam logic [7:0] SP_BASE   = 8'h02;
  localparam logic [7:0] OP_THR    = SP_BASE + 8'(NUM_SP);
  localparam logic [7:0] OP_CAL    = OP_THR + 8'd1;
  localparam logic [7:0] OP_EMER   = OP_THR + 8'd2;
  localparam logic [7:0] OP_MTSOFF = OP_THR + 8'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cal_done = 1'b0;
  logic [NUM_SP*SP_W-1:0] sp_out;
  logic [THR_W-1:0] thrst;
  logic strt_cal, inertial_cal, motors_off, wdog_trip;

  cmd_cfg_gen_if bus ();

  cmd_cfg_gen #(
    .NUM_SP(NUM_SP), .SP_W(SP_W), .THR_W(THR_W), .SP_BASE(SP_BASE),
    .MTR_RAMP(25'(MTR_RAMP_I)), .CAL_TMO(24'(CAL_TMO_I)), .WDOG_CYC(26'(WDOG_I))
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .sp_out(sp_out), .thrst(thrst),
    .strt_cal(strt_cal), .inertial_cal(inertial_cal), .cal_done(cal_done),
    .motors_off(motors_off), .wdog_trip(wdog_trip)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: register contents as plain variables.
  logic [SP_W-1:0]  sp_m [NUM_SP];
  logic [THR_W-1:0] thr_m;
  logic             mo_m;

  task automatic model_reset();
    for (int i = 0; i < NUM_SP; i++) sp_m[i] = '0;
    thr_m = '0;
    mo_m  = 1'b1;
  endtask

  function automatic logic [NUM_SP*SP_W-1:0] exp_sp();
    logic [NUM_SP*SP_W-1:0] v;
    for (int i = 0; i < NUM_SP; i++) v[i*SP_W +: SP_W] = sp_m[i];
    return v;
  endfunction

  // Applies a non-CAL command to the model and returns the expected response.
  function automatic logic [7:0] model_cmd(input logic [7:0] op, input logic [15:0] d);
    int ch;
    ch = int'(op) - int'(SP_BASE);
    if (ch >= 0 && ch < NUM_SP) begin
      sp_m[ch] = d[SP_W-1:0];
      return 8'hA5;
    end
    if (op == OP_THR) begin thr_m = d[THR_W-1:0]; return 8'hA5; end
    if (op == OP_EMER) begin
      for (int i = 0; i < NUM_SP; i++) sp_m[i] = '0;
      thr_m = '0;
      return 8'hA5;
    end
    if (op == OP_MTSOFF) begin mo_m = 1'b1; return 8'hA5; end
    return 8'hEE;
  endfunction

  // Presents a command and waits (bounded) for the consume pulse.
  task automatic do_cmd(input logic [7:0] op, input logic [15:0] d,
                        output logic got_clr, output logic got_send, output logic [7:0] got_resp);
    @(posedge clk); #1;
    bus.cmd_rdy = 1'b1; bus.cmd = op; bus.data = d;
    got_clr = 1'b0; got_send = 1'b0; got_resp = 8'h00;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (bus.clr_cmd_rdy) begin
        got_clr = 1'b1; got_send = bus.send_resp; got_resp = bus.resp;
        break;
      end
    end
    @(posedge clk); #1;
    bus.cmd_rdy = 1'b0;
  endtask

  // Issues CAL and follows it to the strt_cal pulse (k = cycles after N+1).
  task automatic cal_start(output logic clr_ok, output logic snd, output logic mo1,
                           output logic ic1, output int k);
    logic [7:0] r;
    do_cmd(OP_CAL, 16'h0000, clr_ok, snd, r);
    @(negedge clk);
    mo1 = motors_off; ic1 = inertial_cal;
    k = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (strt_cal) begin k = i; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.cmd_rdy = 1'b0; bus.cmd = 8'h00; bus.data = 16'h0000; cal_done = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (sp_out !== '0) begin n_bad++; $display("FAIL reset_sp: got %h want 0", sp_out); end
    n_cmp++; if (thrst !== '0) begin n_bad++; $display("FAIL reset_thrst: got %h want 0", thrst); end
    n_cmp++; if (motors_off !== 1'b1) begin n_bad++; $display("FAIL reset_motors_off: got %b want 1", motors_off); end
    n_cmp++; if (inertial_cal !== 1'b0) begin n_bad++; $display("FAIL reset_inertial_cal: got %b want 0", inertial_cal); end
    n_cmp++; if (strt_cal !== 1'b0) begin n_bad++; $display("FAIL reset_strt_cal: got %b want 0", strt_cal); end
    n_cmp++; if (bus.clr_cmd_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_clr: got %b want 0", bus.clr_cmd_rdy); end
    n_cmp++; if (bus.send_resp !== 1'b0) begin n_bad++; $display("FAIL reset_send: got %b want 0", bus.send_resp); end
    n_cmp++; if (bus.resp !== 8'h00) begin n_bad++; $display("FAIL reset_resp: got %h want 00", bus.resp); end
    n_cmp++; if (wdog_trip !== 1'b0) begin n_bad++; $display("FAIL reset_wdog: got %b want 0", wdog_trip); end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_setpoints();
    logic c, s; logic [7:0] r, e;
    logic [7:0]  ops [3] = '{8'h02, 8'h03, 8'h04};
    logic [15:0] dat [3] = '{16'hBEEF, 16'h1F4B, 16'h8DA0};
    for (int i = 0; i < 3; i++) begin
      e = model_cmd(ops[i], dat[i]);
      do_cmd(ops[i], dat[i], c, s, r);
      n_cmp++;
      if (!(c === 1'b1 && s === 1'b1 && r === e))
        begin n_bad++; $display("FAIL sp_ack op %h: clr %b send %b resp %h want 1 1 %h", ops[i], c, s, r, e); end
    end
    @(negedge clk);
    n_cmp++; if (sp_out !== 48'h8DA0_1F4B_BEEF) begin n_bad++; $display("FAIL sp_pack: got %h want 8da01f4bbeef", sp_out); end
    n_cmp++; if (bus.clr_cmd_rdy !== 1'b0) begin n_bad++; $display("FAIL sp_clr_single: got %b want 0", bus.clr_cmd_rdy); end
  endtask

  task automatic test_thrust_emer();
    logic c, s; logic [7:0] r, e;
    e = model_cmd(OP_THR, 16'h0145);
    do_cmd(OP_THR, 16'h0145, c, s, r);
    @(negedge clk);
    n_cmp++; if (thrst !== 9'h145) begin n_bad++; $display("FAIL thrst_set: got %h want 145", thrst); end
    n_cmp++; if (r !== e || s !== 1'b1) begin n_bad++; $display("FAIL thrst_ack: got %h want %h", r, e); end
    e = model_cmd(OP_EMER, 16'h1234);
    do_cmd(OP_EMER, 16'h1234, c, s, r);
    @(negedge clk);
    n_cmp++; if (sp_out !== '0 || thrst !== '0) begin n_bad++; $display("FAIL emer_clear: got %h/%h want 0/0", sp_out, thrst); end
    n_cmp++; if (r !== 8'hA5 || s !== 1'b1) begin n_bad++; $display("FAIL emer_ack: got %h want a5", r); end
    n_cmp++; if (motors_off !== mo_m) begin n_bad++; $display("FAIL emer_motors: got %b want %b", motors_off, mo_m); end
  endtask

  task automatic test_nak();
    logic c, s; logic [7:0] r, e;
    e = model_cmd(8'h02, 16'h1234); do_cmd(8'h02, 16'h1234, c, s, r);
    e = model_cmd(OP_THR, 16'h00AA); do_cmd(OP_THR, 16'h00AA, c, s, r);
    e = model_cmd(8'h3C, 16'hFFFF); do_cmd(8'h3C, 16'hFFFF, c, s, r);
    @(negedge clk);
    n_cmp++; if (!(c === 1'b1 && s === 1'b1 && r === 8'hEE)) begin n_bad++; $display("FAIL nak_resp: got %b %b %h want 1 1 ee", c, s, r); end
    n_cmp++; if (sp_out !== exp_sp() || thrst !== thr_m) begin n_bad++; $display("FAIL nak_unchanged: got %h/%h want %h/%h", sp_out, thrst, exp_sp(), thr_m); end
  endtask

  task automatic test_random();
    logic c, s; logic [7:0] r, e, op; logic [15:0] d; int sel;
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 9);
      if (sel < NUM_SP) op = SP_BASE + 8'(sel);
      else if (sel == 3) op = OP_THR;
      else if (sel == 4) op = OP_EMER;
      else if (sel == 5) op = OP_MTSOFF;
      else begin
        do op = 8'($urandom_range(0, 255)); while (op >= SP_BASE && op <= OP_MTSOFF);
      end
      d = 16'($urandom);
      e = model_cmd(op, d);
      do_cmd(op, d, c, s, r);
      @(negedge clk);
      n_cmp++; if (!(c === 1'b1 && s === 1'b1 && r === e)) begin n_bad++; $display("FAIL rnd_resp op %h: got %b %b %h want 1 1 %h", op, c, s, r, e); end
      n_cmp++; if (sp_out !== exp_sp() || thrst !== thr_m || motors_off !== mo_m)
        begin n_bad++; $display("FAIL rnd_regs op %h: got %h/%h/%b want %h/%h/%b", op, sp_out, thrst, motors_off, exp_sp(), thr_m, mo_m); end
    end
  endtask

  task automatic test_cal_done_ignored();
    int bad = 0;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1; cal_done = 1'b1;
      @(negedge clk);
      if (bus.send_resp || inertial_cal || strt_cal) bad++;
    end
    @(posedge clk); #1; cal_done = 1'b0;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL cal_done_idle: got %0d reactions want 0", bad); end
  endtask

  task automatic test_cal_ok();
    logic c, s, mo1, ic1, gs; logic [7:0] gr; int k, d, extra, strt_n;
    cal_start(c, s, mo1, ic1, k);
    n_cmp++; if (c !== 1'b1 || s !== 1'b0) begin n_bad++; $display("FAIL cal_accept: got clr %b send %b want 1 0", c, s); end
    n_cmp++; if (mo1 !== 1'b0 || ic1 !== 1'b1) begin n_bad++; $display("FAIL cal_motors_on: got mo %b ic %b want 0 1", mo1, ic1); end
    n_cmp++; if (k != MTR_RAMP_I) begin n_bad++; $display("FAIL cal_strt_delay: got %0d want %0d", k, MTR_RAMP_I); end
    d = $urandom_range(1, CAL_TMO_I - 1);
    extra = 0; strt_n = 0; gs = 1'b0; gr = 8'h00;
    for (int j = 1; j <= d; j++) begin
      @(posedge clk); #1; cal_done = (j == d);
      @(negedge clk);
      if (strt_cal) strt_n++;
      if (j < d) begin
        if (bus.send_resp || !inertial_cal) extra++;
      end else begin
        gs = bus.send_resp; gr = bus.resp;
      end
    end
    @(posedge clk); #1; cal_done = 1'b0;
    @(negedge clk);
    mo_m = 1'b0;
    n_cmp++; if (strt_n != 0 || extra != 0) begin n_bad++; $display("FAIL cal_wait: got strt %0d extra %0d want 0 0", strt_n, extra); end
    n_cmp++; if (gs !== 1'b1 || gr !== 8'hA5) begin n_bad++; $display("FAIL cal_done_ack: got %b %h want 1 a5", gs, gr); end
    n_cmp++; if (inertial_cal !== 1'b0 || motors_off !== 1'b0) begin n_bad++; $display("FAIL cal_end: got ic %b mo %b want 0 0", inertial_cal, motors_off); end
  endtask

`ifdef CMD_CFG_WDOG_EN
  task automatic test_wdog();
    logic c, s; logic [7:0] r, e;
    e = model_cmd(OP_THR, 16'h0080);
    do_cmd(OP_THR, 16'h0080, c, s, r);
    repeat (90) @(negedge clk);
    n_cmp++; if (thrst !== 9'h080 || wdog_trip !== 1'b0) begin n_bad++; $display("FAIL wdog_early: got %h %b want 080 0", thrst, wdog_trip); end
    repeat (15) @(negedge clk);
    n_cmp++; if (thrst !== '0 || wdog_trip !== 1'b1) begin n_bad++; $display("FAIL wdog_trip: got %h %b want 000 1", thrst, wdog_trip); end
    thr_m = '0;
    e = model_cmd(OP_MTSOFF, 16'h0000);
    do_cmd(OP_MTSOFF, 16'h0000, c, s, r);
    @(negedge clk);
    n_cmp++; if (wdog_trip !== 1'b0 || motors_off !== 1'b1 || r !== e) begin n_bad++; $display("FAIL wdog_clear: got %b %b %h want 0 1 %h", wdog_trip, motors_off, r, e); end
  endtask
`else
  task automatic test_mtsoff();
    logic c, s; logic [7:0] r, e;
    e = model_cmd(OP_MTSOFF, 16'h0000);
    do_cmd(OP_MTSOFF, 16'h0000, c, s, r);
    @(negedge clk);
    n_cmp++; if (motors_off !== 1'b1 || r !== e || s !== 1'b1) begin n_bad++; $display("FAIL mtsoff: got %b %h want 1 %h", motors_off, r, e); end
    n_cmp++; if (wdog_trip !== 1'b0) begin n_bad++; $display("FAIL wdog_tied: got %b want 0", wdog_trip); end
  endtask
`endif

  task automatic test_cal_timeout();
    logic c, s, mo1, ic1, gs; logic [7:0] gr, r, e; int k, extra;
    for (int rep = 0; rep < 2; rep++) begin
      cal_start(c, s, mo1, ic1, k);
      n_cmp++; if (k != MTR_RAMP_I) begin n_bad++; $display("FAIL tmo_strt rep %0d: got %0d want %0d", rep, k, MTR_RAMP_I); end
      extra = 0; gs = 1'b0; gr = 8'h00;
      for (int j = 1; j <= CAL_TMO_I; j++) begin
        @(posedge clk); #1; cal_done = (rep == 1) && (j == CAL_TMO_I);
        @(negedge clk);
        if (j < CAL_TMO_I) begin
          if (bus.send_resp) extra++;
        end else begin
          gs = bus.send_resp; gr = bus.resp;
        end
      end
      @(posedge clk); #1; cal_done = 1'b0;
      @(negedge clk);
      mo_m = (rep == 0);
      n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL tmo_early rep %0d: got %0d want 0", rep, extra); end
      n_cmp++; if (gs !== 1'b1 || gr !== ((rep == 0) ? 8'hCE : 8'hA5))
        begin n_bad++; $display("FAIL tmo_resp rep %0d: got %b %h want 1 %h", rep, gs, gr, (rep == 0) ? 8'hCE : 8'hA5); end
      n_cmp++; if (motors_off !== mo_m || inertial_cal !== 1'b0)
        begin n_bad++; $display("FAIL tmo_regs rep %0d: got mo %b ic %b want %b 0", rep, motors_off, inertial_cal, mo_m); end
    end
    e = model_cmd(OP_MTSOFF, 16'h0000);
    do_cmd(OP_MTSOFF, 16'h0000, c, s, r);
  endtask

  task automatic test_back_to_back();
    logic c, s, mo1, ic1, gs4, c5, s5; logic [7:0] gr4, r5, e; int k, early;
    cal_start(c, s, mo1, ic1, k);
    early = 0; gs4 = 1'b0; gr4 = 8'h00;
    for (int j = 1; j <= 4; j++) begin
      @(posedge clk); #1;
      if (j == 1) begin bus.cmd_rdy = 1'b1; bus.cmd = OP_THR; bus.data = 16'h00AB; end
      cal_done = (j == 4);
      @(negedge clk);
      if (bus.clr_cmd_rdy) early++;
      if (j == 4) begin gs4 = bus.send_resp; gr4 = bus.resp; end
    end
    @(posedge clk); #1; cal_done = 1'b0;
    @(negedge clk);
    c5 = bus.clr_cmd_rdy; s5 = bus.send_resp; r5 = bus.resp;
    @(posedge clk); #1; bus.cmd_rdy = 1'b0;
    @(negedge clk);
    e = model_cmd(OP_THR, 16'h00AB);
    mo_m = 1'b0;
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL pending_held: got %0d consumes want 0", early); end
    n_cmp++; if (gs4 !== 1'b1 || gr4 !== 8'hA5) begin n_bad++; $display("FAIL pending_cal_ack: got %b %h want 1 a5", gs4, gr4); end
    n_cmp++; if (c5 !== 1'b1 || s5 !== 1'b1 || r5 !== e) begin n_bad++; $display("FAIL pending_consume: got %b %b %h want 1 1 %h", c5, s5, r5, e); end
    n_cmp++; if (thrst !== thr_m || motors_off !== mo_m) begin n_bad++; $display("FAIL pending_regs: got %h %b want %h %b", thrst, motors_off, thr_m, mo_m); end
  endtask

  task automatic test_reset_mid();
    logic c, s; logic [7:0] r, e;
    e = model_cmd(OP_THR, 16'h01C3); do_cmd(OP_THR, 16'h01C3, c, s, r);
    do_cmd(OP_CAL, 16'h0000, c, s, r);
    repeat (5) @(negedge clk);
    #2; rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (motors_off !== 1'b1 || inertial_cal !== 1'b0 || strt_cal !== 1'b0)
      begin n_bad++; $display("FAIL rst_mid_ctrl: got mo %b ic %b sc %b want 1 0 0", motors_off, inertial_cal, strt_cal); end
    n_cmp++; if (thrst !== '0 || sp_out !== '0 || bus.send_resp !== 1'b0)
      begin n_bad++; $display("FAIL rst_mid_regs: got %h %h %b want 0 0 0", thrst, sp_out, bus.send_resp); end
    @(posedge clk); #1; rst_n = 1'b1;
    e = model_cmd(OP_THR, 16'h0022);
    do_cmd(OP_THR, 16'h0022, c, s, r);
    @(negedge clk);
    n_cmp++; if (c !== 1'b1 || r !== e || thrst !== thr_m) begin n_bad++; $display("FAIL rst_mid_idle: got %b %h %h want 1 %h %h", c, r, thrst, e, thr_m); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    bus.cmd_rdy = 1'b0; bus.cmd = 8'h00; bus.data = 16'h0000;
    test_reset();
    test_setpoints();
    test_thrust_emer();
    test_nak();
    test_random();
    test_cal_done_ignored();
    test_cal_ok();
`ifdef CMD_CFG_WDOG_EN
    test_wdog();
`else
    test_mtsoff();
`endif
    test_cal_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
